// File: rtl/coriolis_pkg.sv
// Shared definitions for Coriolis output nodes: FloPoCo single-precision
// word layout, exception-field encodings and IEEE-754 single constants.
package coriolis_pkg;

    // FloPoCo single: {exn[1:0], sign, exp[7:0], frac[22:0]}
    localparam int FPC_W  = 34;
    localparam int IEEE_W = 32;

    localparam logic [1:0] FPC_EXN_ZERO   = 2'b00;
    localparam logic [1:0] FPC_EXN_NORMAL = 2'b01;
    localparam logic [1:0] FPC_EXN_INF    = 2'b10;
    localparam logic [1:0] FPC_EXN_NAN    = 2'b11;

    localparam logic [IEEE_W-1:0] IEEE_QNAN = 32'h7FC0_0000;

    // Field positions inside a FloPoCo word
    localparam int FPC_EXN_MSB  = 33;
    localparam int FPC_EXN_LSB  = 32;
    localparam int FPC_SIGN_BIT = 31;
    localparam int FPC_EXP_MSB  = 30;
    localparam int FPC_EXP_LSB  = 23;
    localparam int FPC_FRAC_MSB = 22;
    localparam int FPC_FRAC_LSB = 0;

endpackage

// File: rtl/coriolis_fpc2ieee.sv
// Pure combinational FloPoCo single (34 bit) to IEEE-754 single (32 bit)
// converter. The exception field selects zero, normal, infinity or NaN;
// NaN always maps to the canonical quiet NaN with the sign dropped.
module coriolis_fpc2ieee
    import coriolis_pkg::*;
(
    input  logic [FPC_W-1:0]  i_fpc,
    output logic [IEEE_W-1:0] o_ieee
);

    logic [1:0]  w_exn;
    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_frac;

    assign w_exn  = i_fpc[FPC_EXN_MSB:FPC_EXN_LSB];
    assign w_sign = i_fpc[FPC_SIGN_BIT];
    assign w_exp  = i_fpc[FPC_EXP_MSB:FPC_EXP_LSB];
    assign w_frac = i_fpc[FPC_FRAC_MSB:FPC_FRAC_LSB];

    // Select the IEEE encoding from the FloPoCo exception field
    always_comb begin
        o_ieee = IEEE_QNAN;
        case (w_exn)
            FPC_EXN_ZERO:   o_ieee = {w_sign, 31'b0};
            FPC_EXN_NORMAL: o_ieee = {w_sign, w_exp, w_frac};
            FPC_EXN_INF:    o_ieee = {w_sign, 8'hFF, 23'b0};
            default:        o_ieee = IEEE_QNAN;
        endcase
    end

endmodule

// File: rtl/coriolis_fpc2ieee_obuf.sv
// Output buffer of the Coriolis leaf kernel: converts the FloPoCo stream to
// IEEE single and holds it in a first-word-fall-through elastic FIFO.
// iready depends only on registered occupancy, so there is no combinational
// path from oready back to the upstream divider.
// Optional build macro CORIOLIS_OBUF_EXC_CNT_EN adds saturating NaN/Inf
// counters (nan_cnt, inf_cnt) with a synchronous clear input (cnt_clr).
module coriolis_fpc2ieee_obuf
    import coriolis_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int IN_W  = 34,
    parameter  int OUT_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ivalid,
    input  logic [IN_W-1:0]  in1,
    output logic             iready,
    output logic             ovalid,
    output logic [OUT_W-1:0] out1,
    input  logic             oready,
    output logic [AW:0]      count
`ifdef CORIOLIS_OBUF_EXC_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [15:0]      nan_cnt,
    output logic [15:0]      inf_cnt
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    generate
        if (IN_W != FPC_W) begin : g_bad_in_w
            $error("coriolis_fpc2ieee_obuf: IN_W must be 34");
        end
        if (OUT_W != IEEE_W) begin : g_bad_out_w
            $error("coriolis_fpc2ieee_obuf: OUT_W must be 32");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("coriolis_fpc2ieee_obuf: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [OUT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic [OUT_W-1:0] w_ieee;
    logic             w_push;
    logic             w_pop;

    coriolis_fpc2ieee u_conv (
        .i_fpc  (in1),
        .o_ieee (w_ieee)
    );

    // A full FIFO refuses a push even when a pop happens in the same cycle
    assign iready = (r_count != FULL_CNT);
    assign ovalid = (r_count != '0);
    assign out1   = r_mem[r_rd_ptr];
    assign count  = r_count;
    assign w_push = ivalid & iready;
    assign w_pop  = ovalid & oready;

    // Storage holds converted words only; it is never reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_ieee;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks push minus pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef CORIOLIS_OBUF_EXC_CNT_EN
    logic [15:0] r_nan_cnt;
    logic [15:0] r_inf_cnt;
    logic [1:0]  w_in_exn;

    assign w_in_exn = in1[FPC_EXN_MSB:FPC_EXN_LSB];
    assign nan_cnt  = r_nan_cnt;
    assign inf_cnt  = r_inf_cnt;

    // Count accepted NaN/Inf words, saturating; clear beats increment
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_nan_cnt <= '0;
            r_inf_cnt <= '0;
        end else if (w_push) begin
            if (w_in_exn == FPC_EXN_NAN && r_nan_cnt != 16'hFFFF) begin
                r_nan_cnt <= r_nan_cnt + 16'd1;
            end
            if (w_in_exn == FPC_EXN_INF && r_inf_cnt != 16'hFFFF) begin
                r_inf_cnt <= r_inf_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_coriolis_fpc2ieee_obuf.sv
// Self-checking bench for coriolis_fpc2ieee_obuf: a negedge scoreboard
// queues the expected IEEE word on every accepted push and compares it on
// every pop; directed checks cover occupancy, ready/valid and reset.
module tb_coriolis_fpc2ieee_obuf;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          ivalid;
    logic [33:0]   in1;
    logic          iready;
    logic          ovalid;
    logic [31:0]   out1;
    logic          oready;
    logic [AW:0]   count;
`ifdef CORIOLIS_OBUF_EXC_CNT_EN
    logic          cnt_clr;
    logic [15:0]   nan_cnt;
    logic [15:0]   inf_cnt;
`endif

    int n_checks = 0;
    int n_errs   = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    coriolis_fpc2ieee_obuf #(.DEPTH(DEPTH), .IN_W(34), .OUT_W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .ivalid (ivalid),
        .in1    (in1),
        .iready (iready),
        .ovalid (ovalid),
        .out1   (out1),
        .oready (oready),
        .count  (count)
`ifdef CORIOLIS_OBUF_EXC_CNT_EN
        ,
        .cnt_clr(cnt_clr),
        .nan_cnt(nan_cnt),
        .inf_cnt(inf_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Reference mapping FloPoCo -> IEEE single
    function automatic logic [31:0] ref_conv(input logic [33:0] w);
        logic [31:0] r;
        case (w[33:32])
            2'b00:   r = {w[31], 31'b0};
            2'b01:   r = w[31:0];
            2'b10:   r = {w[31], 8'hFF, 23'b0};
            default: r = 32'h7FC0_0000;
        endcase
        return r;
    endfunction

    // Scoreboard: sample handshakes mid-cycle, ahead of the posedge that commits them
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (ovalid && oready) begin
                if (sb_q.size() == 0) check_eq("sb_underflow", 64'd1, 64'd0);
                else check_eq("out1", 64'(out1), 64'(sb_q.pop_front()));
            end
            if (ivalid && iready) sb_q.push_back(ref_conv(in1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; ivalid = 1'b0; oready = 1'b0; in1 = '0;
`ifdef CORIOLIS_OBUF_EXC_CNT_EN
        cnt_clr = 1'b0;
`endif
        step(); step();
        rst = 1'b0;
        check_eq("rst_ovalid", 64'(ovalid), 64'd0);
        check_eq("rst_iready", 64'(iready), 64'd1);
        check_eq("rst_count",  64'(count),  64'd0);

        // Single word, first-word-fall-through latency
        ivalid = 1'b1; in1 = 34'h1_3F80_0000; oready = 1'b1;
        step();
        ivalid = 1'b0;
        check_eq("fwft_ovalid", 64'(ovalid), 64'd1);
        check_eq("fwft_out1",   64'(out1),   64'h3F80_0000);
        check_eq("fwft_count",  64'(count),  64'd1);
        step();
        check_eq("pop_count",   64'(count),  64'd0);

        // Exception mapping (values compared by scoreboard)
        ivalid = 1'b1;
        in1 = 34'h0_8000_0000; step();
        check_eq("zero_map", 64'(out1), 64'h8000_0000);
        in1 = 34'h2_0000_0000; step();
        check_eq("inf_map",  64'(out1), 64'h7F80_0000);
        in1 = 34'h3_1234_5678; step();
        check_eq("nan_map",  64'(out1), 64'h7FC0_0000);
        ivalid = 1'b0; step();
`ifdef CORIOLIS_OBUF_EXC_CNT_EN
        check_eq("inf_cnt", 64'(inf_cnt), 64'd1);
        check_eq("nan_cnt", 64'(nan_cnt), 64'd1);
        cnt_clr = 1'b1; ivalid = 1'b1; in1 = 34'h3_0000_0000; step();
        cnt_clr = 1'b0; ivalid = 1'b0;
        check_eq("clr_nan_cnt", 64'(nan_cnt), 64'd0);
        check_eq("clr_inf_cnt", 64'(inf_cnt), 64'd0);
        step(); step();
`endif
        check_eq("drained_count", 64'(count), 64'd0);

        // Fill to full with the sink stalled
        oready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            ivalid = 1'b1; in1 = 34'h1_0000_0000 | 34'(i);
            step();
        end
        check_eq("full_iready", 64'(iready), 64'd0);
        check_eq("full_count",  64'(count),  64'd8);
        in1 = 34'h1_0000_0009; step();
        check_eq("ninth_ignored", 64'(count), 64'd8);
        ivalid = 1'b0; oready = 1'b1; step();
        check_eq("first_pop_iready", 64'(iready), 64'd1);
        check_eq("first_pop_count",  64'(count),  64'd7);
        for (int i = 0; i < 7; i++) step();
        check_eq("fill_drain_count", 64'(count), 64'd0);

        // Full with simultaneous push and pop: push refused
        oready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            ivalid = 1'b1; in1 = 34'h1_0000_0010 | 34'(i);
            step();
        end
        in1 = 34'h1_0000_00AA; oready = 1'b1; step();
        check_eq("full_pp_count", 64'(count), 64'd7);
        oready = 1'b0; step();
        check_eq("retry_count", 64'(count), 64'd8);
        ivalid = 1'b0; oready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check_eq("pp_drain_count", 64'(count), 64'd0);

        // Random traffic with pointer wrap
        for (int i = 0; i < 1000; i++) begin
            ivalid = 1'($urandom_range(0, 1));
            oready = 1'($urandom_range(0, 1));
            in1    = {2'($urandom_range(0, 3)), 32'($urandom)};
            step();
        end
        ivalid = 1'b0; oready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check_eq("rand_count", 64'(count), 64'd0);
        check_eq("rand_sb_empty", 64'(sb_q.size()), 64'd0);

        // Mid-stream reset discards stored words
        oready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            ivalid = 1'b1; in1 = 34'h1_0000_0100 | 34'(i);
            step();
        end
        check_eq("pre_rst_count", 64'(count), 64'd5);
        ivalid = 1'b0; rst = 1'b1; step();
        rst = 1'b0;
        check_eq("mid_rst_ovalid", 64'(ovalid), 64'd0);
        check_eq("mid_rst_count",  64'(count),  64'd0);
        check_eq("mid_rst_iready", 64'(iready), 64'd1);
        ivalid = 1'b1; in1 = 34'h1_4049_0FDB; step();
        ivalid = 1'b0;
        check_eq("post_rst_out1", 64'(out1), 64'h4049_0FDB);
        oready = 1'b1;
        ivalid = 1'b1; in1 = 34'h0_0000_0000; step();
        ivalid = 1'b0; step(); step();
        check_eq("post_rst_count", 64'(count), 64'd0);
        check_eq("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/coriolis_fpc2ieee_obuf.md
Name: coriolis_fpc2ieee_obuf

Overview:
- Downstream stage of the Coriolis leaf kernel nodes.
- Consumes the 34-bit FloPoCo float stream (exn[1:0], sign, exp[7:0], frac[22:0]) produced by FPDiv-based map nodes.
- Converts each word to IEEE-754 single precision and holds it in a small elastic FIFO with valid/ready handshake on both sides.
- Absorbs results still in flight in the upstream divider pipeline when the sink deasserts ready, and drives the 32-bit output stream.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- IN_W, 34, input word width (FloPoCo single); fixed, checked at elaboration.
- OUT_W, 32, output word width (IEEE single).
- AW, $clog2(DEPTH), localparam, pointer width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ivalid  in  1  upstream word valid.
- in1  in  IN_W  upstream FloPoCo word.
- iready  out  1  space available; upstream may push.
- ovalid  out  1  out1 holds a valid word.
- out1  out  OUT_W  IEEE single word, head of FIFO.
- oready  in  1  downstream accepts.
- count  out  AW+1  current occupancy.

Behaviour:
- Reset (clk edge with rst=1): pointers and count to 0; ovalid=0, iready=1, count=0. out1 content is don't-care while ovalid=0.
- rst has priority over push and pop in the same cycle; a mid-stream reset discards all stored words.
- Push: ivalid & iready. Pop: ovalid & oready.
- iready = (count != DEPTH). It depends only on registered state, never on oready, so there is no combinational ready path.
- When full, a push is refused even if a pop occurs in the same cycle.
- First-word-fall-through: ovalid = (count != 0); out1 = mem[rd_ptr]. out1 is stable while ovalid=1 and oready=0.
- Latency: a word pushed into an empty FIFO is visible on out1 with ovalid=1 on the next cycle.
- Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; count saturates at neither end because of the handshake gating.
- Conversion is combinational on in1 before the write; 32-bit words are stored. Mapping by exn:
  - 00 (zero): {sign, 31'b0}
  - 01 (normal): {sign, exp, frac}
  - 10 (inf): {sign, 8'hFF, 23'b0}
  - 11 (NaN): 32'h7FC00000, canonical quiet NaN, sign discarded
- ivalid while iready=0: word ignored, no state change. Upstream must hold it.

Optional Feature:
- Macro: CORIOLIS_OBUF_EXC_CNT_EN.
- When defined:
  - Adds outputs nan_cnt[15:0] and inf_cnt[15:0], plus input cnt_clr.
  - Each counter increments on every accepted push whose exn is 11 (nan_cnt) or 10 (inf_cnt).
  - Counters saturate at 16'hFFFF.
  - Both reset to 0 on rst or cnt_clr; cnt_clr beats an increment in the same cycle.
- When undefined: these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package (coriolis_pkg):
  - FPC_EXN_ZERO/NORMAL/INF/NAN 2-bit constants.
  - FPC_W=34, IEEE_W=32, IEEE_QNAN=32'h7FC00000.
  - Field-slice localparams for exn, sign, exp and frac.
- One natural sub-module: coriolis_fpc2ieee, the pure combinational 34-to-32 converter, reusable by other output nodes.
- The FIFO storage and control stay in this module.

Test Plan:
- After reset, push 34'h1_3F80_0000 with oready=1: next cycle ovalid=1, out1=32'h3F800000; count returns to 0 after the pop.
- Exception mapping:
  - 34'h0_8000_0000 -> 32'h80000000
  - 34'h2_0000_0000 -> 32'h7F800000
  - 34'h3_1234_5678 -> 32'h7FC00000
  - With the macro defined, inf_cnt=1 and nan_cnt=1.
- oready=0, push 8 words 34'h1_0000_0001 .. 34'h1_0000_0008: iready=0 after the 8th push and count=8. A 9th ivalid is ignored. Then oready=1 drains 0x00000001..0x00000008 in order, with iready=1 after the first pop.
- Full FIFO with ivalid=1 and oready=1 in the same cycle: pop occurs, push refused, count=7; the push is accepted on the next cycle.
- Continuous random ivalid/oready for 1000 cycles with pointer wrap: output sequence equals the input sequence converted, with no loss or duplication.
- Assert rst with count=5: next cycle ovalid=0, count=0, iready=1; later pushes are unaffected by the stale words.
